fc_mac_scheduler: RTL and testbench

- Sequences the 20-lane FC multiplier-accumulator over one fully connected layer.
- Streams input-activation words and weight words out of SRAM, and aligns accumulate_reset with the first chunk of each output neuron.
- Writes each finished neuron result to the output SRAM through a write strobe and address.
- Sits between the top-level layer controller (start/done handshake) and the FC datapath: the MAC array and the requant/ReLU stage on the write path.

---
 rtl/fc_pkg.sv | 24 ++
 rtl/fc_mac_scheduler_if.sv | 24 ++
 rtl/fc_sched_delay.sv | 48 ++++
 rtl/fc_mac_scheduler.sv | 120 ++++++++++++
 tb/tb_fc_mac_scheduler.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared FC-layer constants and the MAC scheduler state encoding.
// Pure definitions: no latency, no flow control.
package fc_pkg;

    localparam int MAC_NUM      = 20;
    localparam int DATA_WIDTH   = 8;
    localparam int WEIGHT_WIDTH = 4;
    localparam int ACC_WIDTH    = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } sched_state_e;

    // Per-address tags travelling alongside the SRAM read pipeline.
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } chunk_tag_t;

endpackage

// File: rtl/fc_mac_scheduler_if.sv
// SRAM-side bundle of the FC scheduler: shared read port, MAC load control, output write port.
// Wires only; the scheduler is the master, SRAMs/MAC/requant observe as slave.
interface fc_mac_scheduler_if #(
    parameter int SRC_AW = 6,
    parameter int W_AW   = 15,
    parameter int OUT_AW = 9
);
    logic              sram_ren;
    logic [SRC_AW-1:0] sram_raddr_src;
    logic [W_AW-1:0]   sram_raddr_weight;
    logic              accumulate_reset;
    logic              sram_wen;
    logic [OUT_AW-1:0] sram_waddr;

    modport master (
        output sram_ren, sram_raddr_src, sram_raddr_weight,
        output accumulate_reset, sram_wen, sram_waddr
    );

    modport slave (
        input sram_ren, sram_raddr_src, sram_raddr_weight,
        input accumulate_reset, sram_wen, sram_waddr
    );
endinterface

// File: rtl/fc_sched_delay.sv
// Two-stage tag pipe aligning first/last/neuron with SRAM read data (+1) and MAC output (+2).
// Fixed latency, no stall: the scheduler never pauses mid-layer.
module fc_sched_delay
    import fc_pkg::*;
#(
    parameter int NW = 9
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          in_vld,
    input  logic          in_first,
    input  logic          in_last,
    input  logic [NW-1:0] in_neuron,
    output logic          acc_reset,
    output logic          wen,
    output logic [NW-1:0] waddr
);
    chunk_tag_t    tag1_q, tag1_d;
    logic [NW-1:0] neuron1_q, neuron1_d;
    logic          wen_q, wen_d;
    logic [NW-1:0] waddr_q, waddr_d;

    always_comb begin
        tag1_d    = '{vld: in_vld, first: in_vld & in_first, last: in_vld & in_last};
        neuron1_d = in_neuron;
        wen_d     = tag1_q.vld & tag1_q.last;
        // Write address only moves on a write so it holds between neurons.
        waddr_d   = wen_d ? neuron1_q : waddr_q;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            tag1_q    <= '0;
            neuron1_q <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
        end else begin
            tag1_q    <= tag1_d;
            neuron1_q <= neuron1_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
        end
    end

    assign acc_reset = tag1_q.vld & tag1_q.first;
    assign wen       = wen_q;
    assign waddr     = waddr_q;
endmodule

// File: rtl/fc_mac_scheduler.sv
// Sequences source/weight SRAM reads over one FC layer and strobes each finished neuron out.
// Address stream starts 1 cycle after start, done at OUT_LEN*CHUNKS+3; no backpressure, start ignored while busy.
module fc_mac_scheduler
    import fc_pkg::*;
#(
    parameter int IN_LEN  = 800,
    parameter int OUT_LEN = 500,
    parameter int SRC_AW  = 6,
    parameter int W_AW    = 15,
    parameter int OUT_AW  = 9
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    fc_mac_scheduler_if.master  sram
);
    localparam int CHUNKS = IN_LEN / MAC_NUM;
    localparam logic [SRC_AW-1:0] LAST_CHUNK  = SRC_AW'(CHUNKS - 1);
    localparam logic [OUT_AW-1:0] LAST_NEURON = OUT_AW'(OUT_LEN - 1);

    if ((IN_LEN % MAC_NUM) != 0) begin : g_bad_in_len
        $error("IN_LEN must be a multiple of MAC_NUM");
    end
    if ((64'd1 << SRC_AW) < 64'(CHUNKS)) begin : g_bad_src_aw
        $error("SRC_AW too narrow for IN_LEN/MAC_NUM");
    end
    if ((64'd1 << W_AW) < 64'(OUT_LEN) * 64'(CHUNKS)) begin : g_bad_w_aw
        $error("W_AW too narrow for OUT_LEN*CHUNKS");
    end
    if ((64'd1 << OUT_AW) < 64'(OUT_LEN)) begin : g_bad_out_aw
        $error("OUT_AW too narrow for OUT_LEN");
    end

    sched_state_e      state_q, state_d;
    logic [SRC_AW-1:0] chunk_q, chunk_d;
    logic [OUT_AW-1:0] neuron_q, neuron_d;
    logic [W_AW-1:0]   weight_q, weight_d;
    logic              flush_q, flush_d;
    logic              ren;

    always_comb begin
        state_d  = state_q;
        chunk_d  = chunk_q;
        neuron_d = neuron_q;
        weight_d = weight_q;
        flush_d  = flush_q;
        ren      = 1'b0;
        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                ren      = 1'b1;
                weight_d = weight_q + 1'b1;
                if (chunk_q == LAST_CHUNK) begin
                    chunk_d = '0;
                    if (neuron_q == LAST_NEURON) begin
                        // Counters return to zero so the next layer starts clean.
                        neuron_d = '0;
                        weight_d = '0;
                        flush_d  = 1'b0;
                        state_d  = S_FLUSH;
                    end else begin
                        neuron_d = neuron_q + 1'b1;
                    end
                end else begin
                    chunk_d = chunk_q + 1'b1;
                end
            end
            S_FLUSH: begin
                flush_d = 1'b1;
                if (flush_q) begin
                    flush_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q  <= S_IDLE;
            chunk_q  <= '0;
            neuron_q <= '0;
            weight_q <= '0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            chunk_q  <= chunk_d;
            neuron_q <= neuron_d;
            weight_q <= weight_d;
            flush_q  <= flush_d;
        end
    end

    fc_sched_delay #(.NW(OUT_AW)) u_delay (
        .clk       (clk),
        .srst      (srst),
        .in_vld    (ren),
        .in_first  (chunk_q == '0),
        .in_last   (chunk_q == LAST_CHUNK),
        .in_neuron (neuron_q),
        .acc_reset (sram.accumulate_reset),
        .wen       (sram.sram_wen),
        .waddr     (sram.sram_waddr)
    );

    assign sram.sram_ren          = ren;
    assign sram.sram_raddr_src    = chunk_q;
    assign sram.sram_raddr_weight = weight_q;
endmodule

// File: tb/tb_fc_mac_scheduler.sv
// Scoreboard bench: two scheduler configs (CHUNKS=2 x3 neurons, CHUNKS=1 x4 neurons) with SRAM/MAC models.
module tb_fc_mac_scheduler;
    import fc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic srst_a, start_a, busy_a, done_a;
    logic srst_b, start_b, busy_b, done_b;

    fc_mac_scheduler_if if_a ();
    fc_mac_scheduler_if if_b ();

    fc_mac_scheduler #(.IN_LEN(40), .OUT_LEN(3)) dut_a (
        .clk(clk), .srst(srst_a), .start(start_a), .busy(busy_a), .done(done_a), .sram(if_a)
    );
    fc_mac_scheduler #(.IN_LEN(20), .OUT_LEN(4)) dut_b (
        .clk(clk), .srst(srst_b), .start(start_b), .busy(busy_b), .done(done_b), .sram(if_b)
    );

    typedef struct {
        int cyc;
        int x;
        int y;
    } ev_t;

    ev_t q_addr[$];
    ev_t q_acc[$];
    ev_t q_wr[$];
    ev_t q_done[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int busy_lo  = 1;
    int busy_hi  = 0;
    bit mon_en   = 1'b0;
    bit sel      = 1'b0;

    // Hand-computed golden tables (cycle offsets from the start cycle).
    int src_a[6]  = '{0, 1, 0, 1, 0, 1};
    int acc_a[3]  = '{2, 4, 6};
    int wr_a[3]   = '{4, 6, 8};
    int dat_a[3]  = '{100, 60, 380};
    int acc_b[4]  = '{2, 3, 4, 5};
    int wr_b[4]   = '{3, 4, 5, 6};
    int dat_b[4]  = '{60, 120, 180, 240};
    // SRAM contents: every lane of a word carries the same value.
    int smem_a[2] = '{1, 2};
    int wmem_a[6] = '{1, 2, 3, 0, 5, 7};
    int wmem_b[4] = '{1, 2, 3, 4};

    logic       o_ren, o_acc, o_wen, o_busy, o_done;
    logic [5:0] o_src;
    logic [14:0] o_w;
    logic [8:0] o_waddr;

    always_comb begin
        o_ren   = sel ? if_b.sram_ren          : if_a.sram_ren;
        o_acc   = sel ? if_b.accumulate_reset  : if_a.accumulate_reset;
        o_wen   = sel ? if_b.sram_wen          : if_a.sram_wen;
        o_src   = sel ? if_b.sram_raddr_src    : if_a.sram_raddr_src;
        o_w     = sel ? if_b.sram_raddr_weight : if_a.sram_raddr_weight;
        o_waddr = sel ? if_b.sram_waddr        : if_a.sram_waddr;
        o_busy  = sel ? busy_b : busy_a;
        o_done  = sel ? done_b : done_a;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int src_val(input int a);
        if (sel) return (a == 0) ? 3 : 0;
        return (a < 2) ? smem_a[a] : 0;
    endfunction

    function automatic int w_val(input int a);
        if (sel) return (a < 4) ? wmem_b[a] : 0;
        return (a < 6) ? wmem_a[a] : 0;
    endfunction

    // Environment: 1-cycle SRAMs feeding a registered MAC.
    bit rd_vld = 1'b0;
    int rd_s   = 0;
    int rd_w   = 0;
    int mac    = 0;

    always @(posedge clk) begin
        rd_vld <= o_ren;
        if (o_ren) begin
            rd_s <= src_val(int'(o_src));
            rd_w <= w_val(int'(o_w));
        end
        if (rd_vld) mac <= (o_acc ? 0 : mac) + MAC_NUM * rd_s * rd_w;
    end

    always @(posedge clk) cyc <= cyc + 1;

    ev_t m_e;
    bit  exp_busy;

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_ren) begin
                chk("addr_pending", int'(q_addr.size() != 0), 1);
                if (q_addr.size() != 0) begin
                    m_e = q_addr.pop_front();
                    chk("addr_cycle", cyc, m_e.cyc);
                    chk("raddr_src", int'(o_src), m_e.x);
                    chk("raddr_weight", int'(o_w), m_e.y);
                end
            end
            if (o_acc) begin
                chk("acc_pending", int'(q_acc.size() != 0), 1);
                if (q_acc.size() != 0) begin
                    m_e = q_acc.pop_front();
                    chk("acc_reset_cycle", cyc, m_e.cyc);
                end
            end
            if (o_wen) begin
                chk("wr_pending", int'(q_wr.size() != 0), 1);
                if (q_wr.size() != 0) begin
                    m_e = q_wr.pop_front();
                    chk("wen_cycle", cyc, m_e.cyc);
                    chk("waddr", int'(o_waddr), m_e.x);
                    chk("wdata", mac, m_e.y);
                end
            end
            if (o_done) begin
                chk("done_pending", int'(q_done.size() != 0), 1);
                if (q_done.size() != 0) begin
                    m_e = q_done.pop_front();
                    chk("done_cycle", cyc, m_e.cyc);
                end
            end
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            chk("busy", int'(o_busy), int'(exp_busy));
            if (!exp_busy)
                chk("idle_outs", int'({o_ren, o_acc, o_wen, o_done, |o_src, |o_w}), 0);
        end
    end

    task automatic drive(input bit use_b, input bit s, input bit r);
        if (use_b) begin
            start_b = s;
            srst_b  = r;
        end else begin
            start_a = s;
            srst_a  = r;
        end
    endtask

    // One layer run; abort_at>0 asserts srst in that cycle offset.
    task automatic run(input bit use_b, input bit repulse, input int abort_at);
        int n_out, chunks, dof, b, lim, ofs;
        n_out  = use_b ? 4 : 3;
        chunks = use_b ? 1 : 2;
        dof    = use_b ? 7 : 9;
        lim    = (abort_at > 0) ? abort_at : 1000;
        sel    = use_b;
        @(posedge clk); #1;
        b = cyc;
        for (int k = 0; k < n_out * chunks; k++)
            if (k + 1 <= lim) q_addr.push_back('{b + k + 1, use_b ? 0 : src_a[k], k});
        for (int n = 0; n < n_out; n++) begin
            ofs = use_b ? acc_b[n] : acc_a[n];
            if (ofs <= lim) q_acc.push_back('{b + ofs, 0, 0});
            ofs = use_b ? wr_b[n] : wr_a[n];
            if (ofs <= lim) q_wr.push_back('{b + ofs, n, use_b ? dat_b[n] : dat_a[n]});
        end
        if (dof <= lim) q_done.push_back('{b + dof, 0, 0});
        busy_lo = b + 1;
        busy_hi = b + ((abort_at > 0) ? abort_at : dof);
        drive(use_b, 1'b1, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            drive(use_b, repulse && (k == 3 || k == 9), abort_at == k);
        end
        drive(use_b, 1'b0, 1'b0);
        chk("queues_drained", q_addr.size() + q_acc.size() + q_wr.size() + q_done.size(), 0);
    endtask

    initial begin
        srst_a  = 1'b1;
        srst_b  = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_waddr_a", int'(if_a.sram_waddr), 0);
        chk("rst_waddr_b", int'(if_b.sram_waddr), 0);
        chk("rst_busy_b", int'(busy_b), 0);
        srst_a = 1'b0;
        srst_b = 1'b0;
        repeat (2) @(posedge clk);

        run(1'b0, 1'b0, 0);
        run(1'b0, 1'b1, 0);
        repeat (3) @(posedge clk);
        run(1'b0, 1'b0, 0);
        run(1'b0, 1'b0, 4);
        repeat (2) @(posedge clk);
        run(1'b0, 1'b0, 0);

        // start coincident with srst must not launch a run.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);

        run(1'b1, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
